// File: rtl/mbist_scheduler_if.sv
// Control and result bundle between the MBIST scheduler, its run controller and the shared engine.
interface mbist_scheduler_if #(
    parameter int unsigned N_MEM = 4,
    parameter int unsigned SEL_W = $clog2(N_MEM)
);
    logic             i_start;
    logic             i_abort;
    logic [N_MEM-1:0] i_mem_mask;
    logic             i_engine_done;
    logic             i_engine_fail;
    logic             o_engine_start;
    logic             o_engine_abort;
    logic [SEL_W-1:0] o_mem_sel;
    logic             o_busy;
    logic             o_done;
    logic [N_MEM-1:0] o_fail_map;
    logic             o_timeout;

    // Controller/engine side: drives requests and engine status, observes the scheduler.
    modport master (
        output i_start, i_abort, i_mem_mask, i_engine_done, i_engine_fail,
        input  o_engine_start, o_engine_abort, o_mem_sel, o_busy, o_done,
               o_fail_map, o_timeout
    );

    // Scheduler side.
    modport slave (
        input  i_start, i_abort, i_mem_mask, i_engine_done, i_engine_fail,
        output o_engine_start, o_engine_abort, o_mem_sel, o_busy, o_done,
               o_fail_map, o_timeout
    );
endinterface

// File: rtl/mbist_scheduler.sv
// Walks the enabled memories in index order, launching one shared BIST engine on each
// and collecting a per-memory pass/fail map with a per-memory WAIT timeout.
module mbist_scheduler #(
    parameter int unsigned N_MEM       = 4,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned SEL_W       = $clog2(N_MEM)
) (
    input  logic             clk,
    input  logic             rst,
    mbist_scheduler_if.slave bus
);

    localparam int unsigned      TMR_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N_MEM - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCAN   = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           r_state;
    logic [SEL_W-1:0] r_idx;
    logic [N_MEM-1:0] r_mask;
    logic [TMR_W-1:0] r_timer;
    logic             r_engine_start;
    logic             r_engine_abort;
    logic             r_busy;
    logic             r_done;
    logic [N_MEM-1:0] r_fail_map;
    logic             r_timeout;

    logic w_idx_last;
    logic w_mask_hit;
    logic w_tmr_last;

    assign w_idx_last = (r_idx == IDX_LAST);
    assign w_mask_hit = r_mask[r_idx];
    assign w_tmr_last = (r_timer == TMR_LAST);

    // Scheduler FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_mask         <= '0;
            r_timer        <= '0;
            r_engine_start <= 1'b0;
            r_engine_abort <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_fail_map     <= '0;
            r_timeout      <= 1'b0;
        end else begin
            r_engine_start <= 1'b0;
            r_engine_abort <= 1'b0;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.i_start) begin
                        r_mask     <= bus.i_mem_mask;
                        r_idx      <= '0;
                        r_fail_map <= '0;
                        r_timeout  <= 1'b0;
                        if (bus.i_mem_mask == '0) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_SCAN;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end
                end

                S_SCAN: begin
                    if (bus.i_abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_mask_hit) begin
                        r_state        <= S_LAUNCH;
                        r_engine_start <= 1'b1;
                    end else if (w_idx_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx <= r_idx + SEL_W'(1);
                    end
                end

                S_LAUNCH: begin
                    if (bus.i_abort) begin
                        r_state        <= S_IDLE;
                        r_busy         <= 1'b0;
                        r_engine_abort <= 1'b1;
                    end else begin
                        r_timer <= '0;
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (bus.i_abort) begin
                        r_state        <= S_IDLE;
                        r_busy         <= 1'b0;
                        r_engine_abort <= 1'b1;
                    end else if (bus.i_engine_done || w_tmr_last) begin
                        // A done arriving on the last allowed cycle beats the timeout.
                        if (bus.i_engine_done) begin
                            r_fail_map[r_idx] <= bus.i_engine_fail;
                        end else begin
                            r_fail_map[r_idx] <= 1'b1;
                            r_timeout         <= 1'b1;
                            r_engine_abort    <= 1'b1;
                        end
                        if (w_idx_last) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx   <= r_idx + SEL_W'(1);
                            r_state <= S_SCAN;
                        end
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_engine_start = r_engine_start;
    assign bus.o_engine_abort = r_engine_abort;
    assign bus.o_mem_sel      = r_idx;
    assign bus.o_busy         = r_busy;
    assign bus.o_done         = r_done;
    assign bus.o_fail_map     = r_fail_map;
    assign bus.o_timeout      = r_timeout;

endmodule

// File: tb/tb_mbist_scheduler.sv
`timescale 1ns/1ps
// Bench for mbist_scheduler: directed run table, abort/reset corner sequences and
// randomized runs scored against a run-level model of the scheduling rules.
module tb_mbist_scheduler;
    localparam int N_MEM  = 4;
    localparam int TO     = 16;
    localparam int SEL_W  = 2;
    localparam int BUDGET = 300;
    localparam int N_RAND = 60;
    localparam int N_VEC  = 10;

    typedef struct {
        string            name;
        logic [3:0]       mask;
        logic [3:0][7:0]  lat;
        logic [3:0]       fl;
        logic [3:0]       exp_map;
        logic             exp_to;
        int               exp_len;
        int               exp_aborts;
        int               exp_abort_cyc;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mbist_scheduler_if #(.N_MEM(N_MEM), .SEL_W(SEL_W)) bus ();

    mbist_scheduler #(.N_MEM(N_MEM), .TIMEOUT_CYC(TO), .SEL_W(SEL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Engine model: done arrives eng_lat cycles after the start pulse (0 = never).
    int               eng_lat [N_MEM];
    logic             eng_fl  [N_MEM];
    int               eng_cnt;
    bit               eng_pend;
    logic [SEL_W-1:0] eng_sel;

    int         obs_len, obs_busy, obs_aborts, obs_abort_cyc, obs_sel_err;
    logic [3:0] obs_starts, obs_map;
    bit         obs_order_ok, obs_finished;
    logic       obs_to, obs_done, obs_busy_end;

    vec_t vecs [N_VEC];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_start       = 1'b0;
        bus.i_abort       = 1'b0;
        bus.i_engine_done = 1'b0;
        bus.i_engine_fail = 1'b0;
    endtask

    // Run-level reference: every index costs one SCAN cycle, each enabled memory a LAUNCH
    // cycle plus its WAIT cycles, capped at TO cycles with a forced fail and an abort.
    task automatic model(input logic [3:0] mask, output int len, output int busy,
                         output logic [3:0] map, output logic to, output int aborts);
        busy = 0; map = '0; to = 1'b0; aborts = 0;
        if (mask != 4'b0000) begin
            busy = N_MEM;
            for (int k = 0; k < N_MEM; k++) begin
                if (mask[k]) begin
                    if (eng_lat[k] >= 1 && eng_lat[k] <= TO) begin
                        busy  += 1 + eng_lat[k];
                        map[k] = eng_fl[k];
                    end else begin
                        busy  += 1 + TO;
                        map[k] = 1'b1;
                        to     = 1'b1;
                        aborts++;
                    end
                end
            end
        end
        len = busy + 1;
    endtask

    // Start a run and follow it cycle by cycle until DONE, or until IDLE after an abort.
    task automatic do_run(input logic [3:0] mask, input int abort_mem, input int abort_dly,
                          input bit noise_start);
        int cyc;
        int last_sel;
        int abort_in;
        bit aborted;
        clear_inputs();
        bus.i_mem_mask = mask;
        bus.i_start    = 1'b1;
        tick();
        bus.i_mem_mask = 4'($urandom);
        obs_len = 0; obs_busy = 0; obs_aborts = 0; obs_abort_cyc = 0; obs_sel_err = 0;
        obs_starts = '0; obs_order_ok = 1'b1; obs_finished = 1'b0;
        last_sel = -1; abort_in = -1; aborted = 1'b0; eng_pend = 1'b0;
        for (cyc = 1; cyc <= BUDGET; cyc++) begin
            clear_inputs();
            if (bus.o_busy) obs_busy++;
            if (bus.o_engine_abort) begin
                obs_aborts++;
                if (obs_abort_cyc == 0) obs_abort_cyc = cyc;
                eng_pend = 1'b0;
            end
            if (eng_pend && bus.o_mem_sel != eng_sel) obs_sel_err++;
            if (bus.o_engine_start) begin
                if (int'(bus.o_mem_sel) <= last_sel) obs_order_ok = 1'b0;
                last_sel = int'(bus.o_mem_sel);
                obs_starts[bus.o_mem_sel] = 1'b1;
                eng_sel  = bus.o_mem_sel;
                eng_pend = 1'b1;
                eng_cnt  = eng_lat[bus.o_mem_sel];
                if (abort_mem == int'(bus.o_mem_sel)) abort_in = abort_dly;
            end else if (eng_pend) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    bus.i_engine_done = 1'b1;
                    bus.i_engine_fail = eng_fl[eng_sel];
                    eng_pend = 1'b0;
                end
            end
            if (abort_in == 0) begin
                bus.i_abort = 1'b1;
                aborted     = 1'b1;
                abort_in    = -1;
            end else if (abort_in > 0) begin
                abort_in--;
            end
            if (noise_start && bus.o_busy && $urandom_range(0, 7) == 0) begin
                bus.i_start    = 1'b1;
                bus.i_mem_mask = 4'($urandom);
            end
            if (bus.o_done || (aborted && !bus.o_busy && !bus.i_abort)) begin
                obs_len      = cyc;
                obs_finished = 1'b1;
                break;
            end
            tick();
        end
        clear_inputs();
        obs_map      = bus.o_fail_map;
        obs_to       = bus.o_timeout;
        obs_done     = bus.o_done;
        obs_busy_end = bus.o_busy;
        check("run_finished", int'(obs_finished), 1);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, ".start"}, int'(bus.o_engine_start), 0);
        check({tag, ".abort"}, int'(bus.o_engine_abort), 0);
        check({tag, ".sel"},   int'(bus.o_mem_sel), 0);
        check({tag, ".busy"},  int'(bus.o_busy), 0);
        check({tag, ".done"},  int'(bus.o_done), 0);
        check({tag, ".map"},   int'(bus.o_fail_map), 0);
        check({tag, ".to"},    int'(bus.o_timeout), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] m, e_map;
        logic       e_to;
        int         e_len, e_busy, e_ab;

        vecs[0] = '{name:"all4_fail2", mask:4'b1111, lat:{8'd5, 8'd5, 8'd5, 8'd5}, fl:4'b0100,
                    exp_map:4'b0100, exp_to:1'b0, exp_len:29, exp_aborts:0, exp_abort_cyc:0};
        vecs[1] = '{name:"sparse_1010", mask:4'b1010, lat:{8'd3, 8'd3, 8'd3, 8'd3}, fl:4'b0000,
                    exp_map:4'b0000, exp_to:1'b0, exp_len:13, exp_aborts:0, exp_abort_cyc:0};
        vecs[2] = '{name:"timeout_m0", mask:4'b0001, lat:{8'd0, 8'd0, 8'd0, 8'd0}, fl:4'b0000,
                    exp_map:4'b0001, exp_to:1'b1, exp_len:22, exp_aborts:1, exp_abort_cyc:19};
        vecs[3] = '{name:"done_at_limit", mask:4'b0001, lat:{8'd0, 8'd0, 8'd0, 8'd16}, fl:4'b0000,
                    exp_map:4'b0000, exp_to:1'b0, exp_len:22, exp_aborts:0, exp_abort_cyc:0};
        vecs[4] = '{name:"done_at_limit_f", mask:4'b0001, lat:{8'd0, 8'd0, 8'd0, 8'd16}, fl:4'b0001,
                    exp_map:4'b0001, exp_to:1'b0, exp_len:22, exp_aborts:0, exp_abort_cyc:0};
        vecs[5] = '{name:"empty_mask", mask:4'b0000, lat:{8'd2, 8'd2, 8'd2, 8'd2}, fl:4'b1111,
                    exp_map:4'b0000, exp_to:1'b0, exp_len:1, exp_aborts:0, exp_abort_cyc:0};
        vecs[6] = '{name:"last_only_fail", mask:4'b1000, lat:{8'd1, 8'd1, 8'd1, 8'd1}, fl:4'b1000,
                    exp_map:4'b1000, exp_to:1'b0, exp_len:7, exp_aborts:0, exp_abort_cyc:0};
        vecs[7] = '{name:"mix_timeout", mask:4'b0110, lat:{8'd0, 8'd0, 8'd15, 8'd0}, fl:4'b0000,
                    exp_map:4'b0100, exp_to:1'b1, exp_len:38, exp_aborts:1, exp_abort_cyc:37};
        vecs[8] = '{name:"timeout_last", mask:4'b1000, lat:{8'd0, 8'd0, 8'd0, 8'd0}, fl:4'b0000,
                    exp_map:4'b1000, exp_to:1'b1, exp_len:22, exp_aborts:1, exp_abort_cyc:22};
        vecs[9] = '{name:"lat1_all", mask:4'b1111, lat:{8'd1, 8'd1, 8'd1, 8'd1}, fl:4'b1001,
                    exp_map:4'b1001, exp_to:1'b0, exp_len:13, exp_aborts:0, exp_abort_cyc:0};

        rst = 1'b1;
        clear_inputs();
        bus.i_mem_mask = '0;
        eng_pend = 1'b0; eng_cnt = 0; eng_sel = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("reset");
        rst = 1'b0;
        tick();

        // Engine done and abort while idle must not move the scheduler.
        bus.i_engine_done = 1'b1; bus.i_engine_fail = 1'b1; bus.i_abort = 1'b1;
        repeat (3) tick();
        clear_inputs();
        tick();
        check_idle_zero("idle_noise");

        foreach (vecs[i]) begin
            for (int k = 0; k < N_MEM; k++) begin
                eng_lat[k] = int'(vecs[i].lat[k]);
                eng_fl[k]  = vecs[i].fl[k];
            end
            do_run(vecs[i].mask, -1, 0, 1'b0);
            check({vecs[i].name, ".len"},     obs_len, vecs[i].exp_len);
            check({vecs[i].name, ".busy"},    obs_busy, vecs[i].exp_len - 1);
            check({vecs[i].name, ".map"},     int'(obs_map), int'(vecs[i].exp_map));
            check({vecs[i].name, ".to"},      int'(obs_to), int'(vecs[i].exp_to));
            check({vecs[i].name, ".done"},    int'(obs_done), 1);
            check({vecs[i].name, ".starts"},  int'(obs_starts), int'(vecs[i].mask));
            check({vecs[i].name, ".order"},   int'(obs_order_ok), 1);
            check({vecs[i].name, ".aborts"},  obs_aborts, vecs[i].exp_aborts);
            check({vecs[i].name, ".abt_cyc"}, obs_abort_cyc, vecs[i].exp_abort_cyc);
            check({vecs[i].name, ".sel"},     obs_sel_err, 0);
        end

        // i_abort in DONE is ignored; the last table run left map 1001 in DONE.
        bus.i_abort = 1'b1;
        tick();
        bus.i_abort = 1'b0;
        tick();
        check("done_abort.done", int'(bus.o_done), 1);
        check("done_abort.map",  int'(bus.o_fail_map), 4'b1001);
        check("done_abort.pls",  int'(bus.o_engine_abort), 0);

        // Abort in WAIT of memory 2 after memories 0 and 1 pass.
        eng_lat = '{3, 3, 3, 3};
        eng_fl  = '{1'b0, 1'b0, 1'b0, 1'b0};
        do_run(4'b1111, 2, 1, 1'b0);
        check("abort_wait.len",    obs_len, 14);
        check("abort_wait.aborts", obs_aborts, 1);
        check("abort_wait.abtcyc", obs_abort_cyc, 14);
        check("abort_wait.busy",   int'(obs_busy_end), 0);
        check("abort_wait.done",   int'(obs_done), 0);
        check("abort_wait.map",    int'(obs_map), 0);
        check("abort_wait.starts", int'(obs_starts), 4'b0111);
        bus.i_mem_mask = 4'b0000; bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        check("empty_after_abort.done", int'(bus.o_done), 1);
        check("empty_after_abort.busy", int'(bus.o_busy), 0);

        // Abort in LAUNCH of memory 3 keeps the partial fail from memory 1.
        eng_fl = '{1'b0, 1'b1, 1'b0, 1'b0};
        do_run(4'b1111, 3, 0, 1'b0);
        check("abort_launch.len",    obs_len, 18);
        check("abort_launch.aborts", obs_aborts, 1);
        check("abort_launch.map",    int'(obs_map), 4'b0010);
        check("abort_launch.done",   int'(obs_done), 0);

        // Abort while scanning gives no engine abort pulse.
        bus.i_mem_mask = 4'b1000; bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        check("abort_scan.busy0", int'(bus.o_busy), 1);
        bus.i_abort = 1'b1;
        tick();
        bus.i_abort = 1'b0;
        check("abort_scan.busy",  int'(bus.o_busy), 0);
        check("abort_scan.pulse", int'(bus.o_engine_abort), 0);
        check("abort_scan.done",  int'(bus.o_done), 0);
        repeat (5) tick();
        check("abort_scan.stay",  int'(bus.o_engine_start), 0);

        // Reset between edges in WAIT of memory 1, after memory 0 recorded a fail.
        bus.i_mem_mask = 4'b0011; bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        tick(); tick(); tick();
        bus.i_engine_done = 1'b1; bus.i_engine_fail = 1'b1;
        tick();
        clear_inputs();
        tick();
        check("pre_rst.start", int'(bus.o_engine_start), 1);
        tick(); tick();
        check("pre_rst.map",  int'(bus.o_fail_map), 4'b0001);
        check("pre_rst.sel",  int'(bus.o_mem_sel), 1);
        check("pre_rst.busy", int'(bus.o_busy), 1);
        #2 rst = 1'b1;
        #1;
        check_idle_zero("mid_rst");
        #2 rst = 1'b0;
        eng_lat = '{5, 5, 5, 5};
        eng_fl  = '{1'b0, 1'b0, 1'b1, 1'b0};
        tick();
        do_run(4'b1111, -1, 0, 1'b0);
        check("post_rst.len", obs_len, 29);
        check("post_rst.map", int'(obs_map), 4'b0100);
        check("post_rst.to",  int'(obs_to), 0);

        for (int r = 0; r < N_RAND; r++) begin
            m = 4'($urandom);
            for (int k = 0; k < N_MEM; k++) begin
                case ($urandom_range(0, 9))
                    0:       eng_lat[k] = 0;
                    1:       eng_lat[k] = TO;
                    2:       eng_lat[k] = TO + 1;
                    3:       eng_lat[k] = TO - 1;
                    default: eng_lat[k] = int'($urandom_range(1, 8));
                endcase
                eng_fl[k] = 1'($urandom_range(0, 1));
            end
            model(m, e_len, e_busy, e_map, e_to, e_ab);
            do_run(m, -1, 0, 1'b1);
            check($sformatf("rnd%0d.len", r),    obs_len, e_len);
            check($sformatf("rnd%0d.busy", r),   obs_busy, e_busy);
            check($sformatf("rnd%0d.map", r),    int'(obs_map), int'(e_map));
            check($sformatf("rnd%0d.to", r),     int'(obs_to), int'(e_to));
            check($sformatf("rnd%0d.done", r),   int'(obs_done), 1);
            check($sformatf("rnd%0d.starts", r), int'(obs_starts), int'(m));
            check($sformatf("rnd%0d.order", r),  int'(obs_order_ok), 1);
            check($sformatf("rnd%0d.aborts", r), obs_aborts, e_ab);
            check($sformatf("rnd%0d.sel", r),    obs_sel_err, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
